r4u3_one_ctrl: RTL and testbench

R4U3_ONE_CTRL -- requirements
Module: r4u3_one_ctrl

---
 rtl/r4u3_one_ctrl.sv | 138 +++++++++++++
 tb/tb_r4u3_one_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/r4u3_one_ctrl.sv
// Radix-4 stage-one controller: fills a frame into RAM in natural order,
// then drains it in butterfly order (k, k+S, k+2S, k+3S).
`ifndef MAN_WIDTH
`define MAN_WIDTH 12
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 8
`endif

module r4u3_one_ctrl #(
   parameter int W = `MAN_WIDTH+`MAN_WIDTH+`EXP_WIDTH
) (
   input  logic         clk_sys,
   input  logic         rst_sys,
   input  logic [1:0]   cfg_len,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         ram_wr_en,
   output logic [7:0]   ram_wr_addr,
   output logic [W-1:0] ram_wr_data,
   output logic [7:0]   ram_rd_addr,
   input  logic [W-1:0] ram_rd_data,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic [1:0]   out_leg,
   output logic         out_sof,
   output logic         out_eof,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_wr_cnt;
   logic [7:0]  r_rd_cnt;
   logic [7:0]  r_len_m1;
   logic [7:0]  w_cfg_m1;
   logic [7:0]  w_len_m1;
   logic [7:0]  w_s;
   logic [7:0]  w_k;
   logic [1:0]  w_j;
   logic        w_acc;
   logic        w_wr_last;
   logic        w_rd_last;
   logic        r_out_valid;
   logic [1:0]  r_out_leg;
   logic        r_out_sof;
   logic        r_out_eof;

   // Length is held as len-1 so the last-index compare needs no subtract
   always_comb begin
      w_cfg_m1 = 8'd255;
      unique case (cfg_len)
         2'd0:    w_cfg_m1 = 8'd15;
         2'd1:    w_cfg_m1 = 8'd63;
         default: w_cfg_m1 = 8'd255;
      endcase
   end

   assign w_len_m1  = (r_state == S_IDLE) ? w_cfg_m1 : r_len_m1;
   assign in_ready  = !rst_sys && (r_state != S_DRAIN);
   assign w_acc     = in_valid && in_ready;
   assign w_wr_last = w_acc && (r_wr_cnt == w_len_m1);
   assign w_rd_last = (r_state == S_DRAIN) && (r_rd_cnt == r_len_m1);

   assign ram_wr_en   = ~w_acc;
   assign ram_wr_addr = r_wr_cnt;
   assign ram_wr_data = in_data;

   assign w_j = r_rd_cnt[1:0];
   assign w_k = {2'b00, r_rd_cnt[7:2]};
   assign w_s = (r_len_m1 >> 2) + 8'd1;

   assign ram_rd_addr = (r_state == S_DRAIN) ?
                        ({6'd0, w_j} * w_s + w_k) : 8'd0;

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_acc)     w_next = S_FILL;
         S_FILL:  if (w_wr_last) w_next = S_DRAIN;
         S_DRAIN: if (w_rd_last) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         r_wr_cnt <= 8'd0;
         r_len_m1 <= 8'd255;
      end else if (w_acc) begin
         if (r_state == S_IDLE) r_len_m1 <= w_cfg_m1;
         r_wr_cnt <= w_wr_last ? 8'd0 : r_wr_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         r_rd_cnt <= 8'd0;
      end else if (r_state == S_DRAIN) begin
         r_rd_cnt <= w_rd_last ? 8'd0 : r_rd_cnt + 8'd1;
      end
   end

   // Output tags line up with the RAM's one-cycle read latency
   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         r_out_valid <= 1'b0;
         r_out_leg   <= 2'd0;
         r_out_sof   <= 1'b0;
         r_out_eof   <= 1'b0;
      end else begin
         r_out_valid <= (r_state == S_DRAIN);
         r_out_leg   <= (r_state == S_DRAIN) ? w_j : 2'd0;
         r_out_sof   <= (r_state == S_DRAIN) && (r_rd_cnt == 8'd0);
         r_out_eof   <= w_rd_last;
      end
   end

   assign out_valid = r_out_valid;
   assign out_leg   = r_out_leg;
   assign out_sof   = r_out_sof;
   assign out_eof   = r_out_eof;
   assign out_data  = ram_rd_data;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_r4u3_one_ctrl.sv
// Directed bench for r4u3_one_ctrl with a registered-read RAM model.
module tb_r4u3_one_ctrl;

   localparam int W = 32;

   logic         clk;
   logic         rst;
   logic [1:0]   cfg_len;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         ram_wr_en;
   logic [7:0]   ram_wr_addr;
   logic [W-1:0] ram_wr_data;
   logic [7:0]   ram_rd_addr;
   logic [W-1:0] ram_rd_data;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_leg;
   logic         out_sof;
   logic         out_eof;
   logic         busy;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mem [256];

   r4u3_one_ctrl #(.W(W)) dut (
      .clk_sys    (clk),
      .rst_sys    (rst),
      .cfg_len    (cfg_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .ram_wr_en  (ram_wr_en),
      .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data),
      .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_leg    (out_leg),
      .out_sof    (out_sof),
      .out_eof    (out_eof),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eaddr(input int len, input int n);
      return (n % 4) * (len / 4) + n / 4;
   endfunction

   task automatic chkout(input int len, input int base, input int n);
      int tbl16 [16] = '{0, 4, 8, 12, 1, 5, 9, 13,
                         2, 6, 10, 14, 3, 7, 11, 15};
      logic [4:0] ef;
      ef = {1'b1, 2'(n % 4), (n == 0), (n == len - 1)};
      chk("out_data", out_data, base + eaddr(len, n));
      chk("out_flags", {out_valid, out_leg, out_sof, out_eof}, ef);
      if (len == 16) chk("ord16", out_data - base, tbl16[n]);
   endtask

   task automatic fill(input int code, input int code_rest, input int first,
                       input int n, input int base, input bit gap);
      for (int i = first; i < n; i++) begin
         if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("gap_wen", ram_wr_en, 1);
            chk("gap_rdy", in_ready, 1);
         end
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = base + i;
         cfg_len  = (i == 0) ? 2'(code) : 2'(code_rest);
         #1;
         chk("fill_rdy", in_ready, 1);
         chk("fill_wen", ram_wr_en, 0);
         chk("fill_addr", ram_wr_addr, i);
         chk("fill_wdat", ram_wr_data, base + i);
      end
   endtask

   task automatic drain(input int len, input int base, input int abort_at,
                        input bit hold, input int next_data);
      int zc;
      int k63 [4] = '{63, 127, 191, 255};
      zc = 0;
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         if (!hold) in_valid = 1'b0;
         #1;
         if (n == abort_at) begin
            rst = 1'b1;
            #1;
            chk("rst_oval", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rdy", in_ready, 0);
            chk("rst_wen", ram_wr_en, 1);
            chk("rst_raddr", ram_rd_addr, 0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (!in_ready) zc++;
         chk("drn_wen", ram_wr_en, 1);
         chk("drn_busy", busy, 1);
         chk("drn_raddr", ram_rd_addr, eaddr(len, n));
         if (len == 256 && n >= 252)
            chk("k63_addr", ram_rd_addr, k63[n - 252]);
         if (n > 0) chkout(len, base, n - 1);
         else       chk("drn_oval0", out_valid, 0);
      end
      @(negedge clk);
      in_data = next_data;
      #1;
      chkout(len, base, len - 1);
      chk("end_busy", busy, 0);
      chk("end_rdy", in_ready, 1);
      chk("end_raddr", ram_rd_addr, 0);
      chk("end_wen", ram_wr_en, hold ? 0 : 1);
      chk("end_waddr", ram_wr_addr, 0);
      chk("rdy_zero_cnt", zc, len);
      if (!hold) begin
         @(negedge clk);
         #1;
         chk("post_oval", out_valid, 0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      cfg_len  = 2'd0;
      in_valid = 1'b1;
      in_data  = '0;
      #1;
      chk("rst_rdy", in_ready, 0);
      chk("rst_wen", ram_wr_en, 1);
      chk("rst_flags", {out_valid, out_leg, out_sof, out_eof}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_raddr", ram_rd_addr, 0);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      chk("idle_rdy", in_ready, 1);
      chk("idle_wen", ram_wr_en, 1);

      fill(0, 0, 0, 16, 0, 1'b0);
      drain(16, 0, -1, 1'b0, 0);

      fill(2, 2, 0, 256, 32'h1000, 1'b0);
      drain(256, 32'h1000, -1, 1'b0, 0);

      fill(1, 1, 0, 64, 32'h2000, 1'b1);
      drain(64, 32'h2000, -1, 1'b0, 0);

      fill(0, 1, 0, 16, 32'h3000, 1'b0);
      drain(16, 32'h3000, -1, 1'b0, 0);
      fill(1, 1, 0, 64, 32'h3100, 1'b0);
      drain(64, 32'h3100, -1, 1'b0, 0);

      fill(1, 1, 0, 64, 32'h4000, 1'b0);
      drain(64, 32'h4000, 20, 1'b0, 0);
      fill(0, 0, 0, 16, 32'h5000, 1'b0);
      drain(16, 32'h5000, -1, 1'b0, 0);

      fill(0, 0, 0, 16, 32'h6000, 1'b0);
      drain(16, 32'h6000, -1, 1'b1, 32'h6100);
      fill(0, 0, 1, 16, 32'h6100, 1'b0);
      drain(16, 32'h6100, -1, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
